// File: rtl/pcs_pkg.sv
// Constants shared by the 10GBASE-R PCS blocks: the scrambler polynomial
// taps and the 64b/66b sync header encodings.
package pcs_pkg;

  localparam int SCR_TAP_A   = 39;
  localparam int SCR_TAP_B   = 58;
  localparam int SCR_STATE_W = 58;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Only 01 and 10 are legal; 00 and 11 mark a corrupted block.
  function automatic logic sync_hdr_bad(input logic [1:0] hdr);
    return hdr[1] == hdr[0];
  endfunction

endpackage

// File: rtl/scrambler_lfsr64.sv
// Combinational 64-bit step of the self-synchronous scrambler
// G(x) = 1 + x^39 + x^58: maps (state, payload) to (scrambled payload, next state).
module scrambler_lfsr64
  import pcs_pkg::*;
(
  input  logic [SCR_STATE_W-1:0] s_in,
  input  logic [63:0]            data_in,
  output logic [63:0]            data_out,
  output logic [SCR_STATE_W-1:0] s_next
);

  // ext[n + SCR_STATE_W] is scrambled bit n of this word; ext[SCR_STATE_W-1:0]
  // is the history, so a single index covers both "previous word" and
  // "earlier in this word" feedback.
  logic [SCR_STATE_W+63:0] ext;

  always_comb begin
    ext = '0;
    ext[SCR_STATE_W-1:0] = s_in;
    for (int i = 0; i < 64; i++) begin
      ext[i + SCR_STATE_W] = data_in[i]
                           ^ ext[i + SCR_STATE_W - SCR_TAP_A]
                           ^ ext[i + SCR_STATE_W - SCR_TAP_B];
    end
  end

  assign data_out = ext[SCR_STATE_W+63:SCR_STATE_W];
  assign s_next   = ext[SCR_STATE_W+63:64];

endmodule

// File: rtl/scrambler.sv
// TX 64b/66b scrambler: scrambles the payload of each valid block, forwards
// the sync header untouched, flags illegal headers; all outputs registered.
module scrambler
  import pcs_pkg::*;
#(
  parameter int                     DATA_WIDTH = 64,
  parameter logic [SCR_STATE_W-1:0] SEED       = 58'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [1:0]             header_in,
  input  logic                   data_in_valid,
  input  logic                   bypass,
  input  logic                   seed_load,
  input  logic [SCR_STATE_W-1:0] seed,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [1:0]             header_out,
  output logic                   data_out_valid,
  output logic                   hdr_err
);

  logic [SCR_STATE_W-1:0] s_q, s_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [1:0]             hdr_q, hdr_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic [SCR_STATE_W-1:0] s_cur;
  logic [DATA_WIDTH-1:0]  scr_data;
  logic [SCR_STATE_W-1:0] scr_s_next;

  // A seed load in the same cycle as a word scrambles that word with the seed.
  assign s_cur = seed_load ? seed : s_q;

  scrambler_lfsr64 u_lfsr (
    .s_in     (s_cur),
    .data_in  (data_in),
    .data_out (scr_data),
    .s_next   (scr_s_next)
  );

  always_comb begin
    s_d     = s_cur;
    data_d  = data_q;
    hdr_d   = hdr_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (data_in_valid) begin
      valid_d = 1'b1;
      hdr_d   = header_in;
      err_d   = sync_hdr_bad(header_in);
      if (bypass) begin
        data_d = data_in;
      end else begin
        data_d = scr_data;
        s_d    = scr_s_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= SEED;
      data_q  <= '0;
      hdr_q   <= 2'b00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out       = data_q;
  assign header_out     = hdr_q;
  assign data_out_valid = valid_q;
  assign hdr_err        = err_q;

endmodule

// File: tb/tb_scrambler.sv
// Self-checking bench for scrambler: random and directed words compared with a
// bit-serial model of the transmitted stream, plus a descrambler model for round trips.
module tb_scrambler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_in = '0;
  logic [1:0]  header_in = 2'b00;
  logic        data_in_valid = 1'b0;
  logic        bypass = 1'b0;
  logic        seed_load = 1'b0;
  logic [57:0] seed = '0;
  logic [63:0] data_out;
  logic [1:0]  header_out;
  logic        data_out_valid;
  logic        hdr_err;

  int total = 0;
  int bad = 0;

  // Model: last 58 transmitted scrambled bits, index 0 oldest, 57 newest.
  bit m_hist[$];
  bit rx_hist[$];
  logic [63:0] exp_data;
  logic [1:0]  exp_hdr;
  logic        exp_valid;
  logic        exp_err;

  always #5 clk = ~clk;

  scrambler #(.DATA_WIDTH(64), .SEED(58'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .header_in      (header_in),
    .data_in_valid  (data_in_valid),
    .bypass         (bypass),
    .seed_load      (seed_load),
    .seed           (seed),
    .data_out       (data_out),
    .header_out     (header_out),
    .data_out_valid (data_out_valid),
    .hdr_err        (hdr_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic model_load(input logic [57:0] s);
    m_hist.delete();
    for (int i = 0; i < 58; i++) m_hist.push_back(s[i]);
  endtask

  // Each transmitted bit = payload bit ^ bit sent 39 ago ^ bit sent 58 ago.
  task automatic model_scramble(input logic [63:0] d, output logic [63:0] q);
    bit b;
    for (int i = 0; i < 64; i++) begin
      b = d[i] ^ m_hist[58 - 39] ^ m_hist[0];
      q[i] = b;
      void'(m_hist.pop_front());
      m_hist.push_back(b);
    end
  endtask

  task automatic rx_descramble(input logic [63:0] r, output logic [63:0] q);
    for (int i = 0; i < 64; i++) begin
      q[i] = r[i] ^ rx_hist[58 - 39] ^ rx_hist[0];
      void'(rx_hist.pop_front());
      rx_hist.push_back(r[i]);
    end
  endtask

  task automatic step(input logic [63:0] d, input logic [1:0] h, input logic v,
                      input logic byp, input logic sl, input logic [57:0] sd);
    logic [63:0] q;
    @(negedge clk);
    data_in = d; header_in = h; data_in_valid = v;
    bypass = byp; seed_load = sl; seed = sd;
    if (sl) model_load(sd);
    exp_valid = v;
    exp_err   = v && (h == 2'b00 || h == 2'b11);
    if (v) begin
      exp_hdr = h;
      if (byp) exp_data = d;
      else begin
        model_scramble(d, q);
        exp_data = q;
      end
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0; seed_load = 1'b0; bypass = 1'b0;
    check("data", data_out, exp_data);
    check("hdr", {62'h0, header_out}, {62'h0, exp_hdr});
    check("valid", {63'h0, data_out_valid}, {63'h0, exp_valid});
    check("hdr_err", {63'h0, hdr_err}, {63'h0, exp_err});
  endtask

  task automatic check_reset_outputs();
    check("rst_data", data_out, 64'h0);
    check("rst_hdr", {62'h0, header_out}, 64'h0);
    check("rst_valid", {63'h0, data_out_valid}, 64'h0);
    check("rst_err", {63'h0, hdr_err}, 64'h0);
  endtask

  initial begin
    logic [63:0] rt_words [3];
    logic [63:0] q;
    logic [63:0] d;
    logic [57:0] sd;
    logic [1:0]  h;

    model_load(58'h0);
    exp_data = '0; exp_hdr = 2'b00; exp_valid = 1'b0; exp_err = 1'b0;
    #2;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Impulse response from a zero seed.
    step(64'h1, 2'b01, 1'b1, 1'b0, 1'b0, '0);
    check("impulse0", data_out, 64'h0400008000000001);
    step(64'h0, 2'b01, 1'b1, 1'b0, 1'b0, '0);
    check("impulse1", data_out, 64'h0030000000004000);
    check("impulse_hdr", {62'h0, header_out}, 64'h1);

    // Asynchronous reset between two words: outputs clear before any edge.
    step($urandom, 2'b10, 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    model_load(58'h0);
    exp_data = '0; exp_hdr = 2'b00;

    // Zero state and zero data stay zero.
    for (int i = 0; i < 16; i++) begin
      step(64'h0, 2'b01, 1'b1, 1'b0, 1'b0, '0);
      check("zero_data", data_out, 64'h0);
    end

    // Round trip through the descrambler model from an arbitrary seed.
    rt_words[0] = 64'h7b2aaad555555555;
    rt_words[1] = 64'h46ff004433221100;
    rt_words[2] = 64'h5e8644a8b2070707;
    sd = {$urandom, $urandom};
    step(64'h0, 2'b01, 1'b0, 1'b0, 1'b1, sd);
    rx_hist.delete();
    for (int i = 0; i < 58; i++) rx_hist.push_back(1'b0);
    for (int w = 0; w < 3; w++) begin
      step(rt_words[w], 2'b01, 1'b1, 1'b0, 1'b0, '0);
      rx_descramble(data_out, q);
      if (w > 0) check("round_trip", q, rt_words[w]);
    end

    // Gap of three idle cycles: outputs hold, valid drops, state frozen.
    step({$urandom, $urandom}, 2'b01, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) step({$urandom, $urandom}, 2'b10, 1'b0, 1'b0, 1'b0, '0);
    step({$urandom, $urandom}, 2'b01, 1'b1, 1'b0, 1'b0, '0);

    // Bypassed word is verbatim and does not advance state.
    d = {$urandom, $urandom};
    step(d, 2'b10, 1'b1, 1'b1, 1'b0, '0);
    check("bypass_verbatim", data_out, d);
    step({$urandom, $urandom}, 2'b01, 1'b1, 1'b0, 1'b0, '0);

    // Illegal header: flagged for one cycle, forwarded, payload scrambled.
    step({$urandom, $urandom}, 2'b11, 1'b1, 1'b0, 1'b0, '0);
    check("hdr_err_pulse", {63'h0, hdr_err}, 64'h1);
    step({$urandom, $urandom}, 2'b01, 1'b0, 1'b0, 1'b0, '0);
    check("hdr_err_clear", {63'h0, hdr_err}, 64'h0);

    // Seed load colliding with a valid word.
    step({$urandom, $urandom}, 2'b01, 1'b1, 1'b0, 1'b1, {$urandom, $urandom});
    step({$urandom, $urandom}, 2'b01, 1'b1, 1'b0, 1'b0, '0);

    // Randomized mix of all controls.
    for (int i = 0; i < 300; i++) begin
      d  = {$urandom, $urandom};
      sd = {$urandom, $urandom};
      h  = 2'($urandom_range(0, 3));
      step(d, h, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0), sd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scrambler.md
# scrambler

Transmit-side 64b/66b self-synchronous scrambler for the 10GBASE-R PCS, polynomial G(x) = 1 + x^39 + x^58. Sits between the TX 64b/66b encoder and the gearbox, and is the counterpart of `descrambler` on the receive path. Scrambles the 64-bit payload of each valid block, passes the 2-bit sync header unscrambled, and registers all outputs. A scrambler output fed to `descrambler` reproduces the original payload after the descrambler's 58-bit history is primed, i.e. from the second valid word onward.

## Interface
- `DATA_WIDTH`, 64, payload width; only 64 is supported.
- `SEED`, 58'h0, scrambler state loaded on reset.
- `clk` input 1 — sole clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `data_in` input 64 — payload; bit 0 is transmitted first.
- `header_in` input 2 — sync header, 2'b01 data / 2'b10 control.
- `data_in_valid` input 1 — qualifies `data_in`/`header_in` this cycle.
- `bypass` input 1 — when 1, the payload passes unscrambled and state is frozen.
- `seed_load` input 1 — load `seed` into the scrambler state.
- `seed` input 58 — value for `seed_load`.
- `data_out` output 64 — scrambled payload.
- `header_out` output 2 — registered copy of `header_in`.
- `data_out_valid` output 1 — qualifies `data_out`/`header_out`.
- `hdr_err` output 1 — one-cycle pulse: a valid word carried header 2'b00 or 2'b11.

## Operation
- State S[57:0] holds the last 58 scrambled bits; S[57] is the most recent (the previous word's `data_out[63]`).
- Define b(n) = out[n] for n ≥ 0, and b(n) = S[58+n] for n < 0.
- For i = 0..63: out[i] = in[i] ^ b(i−39) ^ b(i−58). This is evaluated in bit order, so bits within a word feed back into later bits of the same word.
- After a scrambled word: S <= out[63:6].
- `data_in_valid` = 0:
  - S holds.
  - `data_out_valid` <= 0.
  - `data_out` and `header_out` hold their last values.
  - `hdr_err` <= 0.
- `data_in_valid` = 1 and `bypass` = 1:
  - `data_out` <= `data_in`.
  - S holds.
  - The header passes through.
- `seed_load` = 1 has priority over the S update. If `data_in_valid` is also 1 in that cycle, the word is scrambled using `seed` as S, and the post-word S is derived from that result.
- `seed_load` with `data_in_valid` = 0: S <= `seed`.
- Header is never scrambled. `header_out` <= `header_in` on every valid word.
- `hdr_err` <= `data_in_valid` & (`header_in[1]` == `header_in[0]`). An invalid header is still forwarded unchanged.
- `bypass` changing mid-stream takes effect on the same-cycle word. S resumes from its frozen value when `bypass` returns to 0.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on the outputs after edge k; `data_out_valid` is high for cycle k+1.
- Throughput is one word per clock. Back-to-back valid words need no bubbles.
- There is no backpressure; the downstream gearbox always accepts.
- While `rst` is asserted, asynchronously:
  - S = `SEED`.
  - `data_out` = 0, `header_out` = 2'b00.
  - `data_out_valid` = 0, `hdr_err` = 0.
- Reset mid-stream drops the in-flight word. The first valid word after deassertion uses S = `SEED`.
- `rst` deassertion is synchronous to `clk` at system level.

## Structure
- Package `pcs_pkg` holds:
  - `SCR_TAP_A` = 39, `SCR_TAP_B` = 58, `SCR_STATE_W` = 58.
  - `SYNC_DATA` = 2'b01, `SYNC_CTRL` = 2'b10.
  - These are shared with `descrambler` and the encoder/decoder.
- Sub-module `scrambler_lfsr64`: purely combinational. Maps (S, `data_in`) to (out, next S) using the recurrence above. The top level holds the registers, bypass/seed muxing, and header check.

## Test plan
- Single-word impulse:
  - Stimulus: reset, `SEED` = 0; valid word `data_in` = 64'h1, header 2'b01, then valid 64'h0.
  - Required: `data_out` = 64'h0400008000000001, then 64'h0030000000004000. `header_out` = 2'b01 on both.
- Zero state and zero data:
  - Stimulus: 16 valid words of 0 with `SEED` = 0.
  - Required: every `data_out` = 0 and `data_out_valid` high for 16 cycles.
- Round trip:
  - Stimulus: feed 64'h7b2aaad555555555, 64'h46ff004433221100, 64'h5e8644a8b2070707 through `scrambler` → `descrambler` from arbitrary `seed_load` state.
  - Required: the 2nd and 3rd words recovered exactly.
- Gaps and bypass:
  - Stimulus: valid, idle 3 cycles, valid. Then a word with `bypass` = 1.
  - Required: the post-gap output equals the gapless reference. The bypassed word is output verbatim and the next scrambled word matches the reference with that word skipped.
- Header error:
  - Stimulus: valid word with header 2'b11.
  - Required: `hdr_err` = 1 for exactly one cycle, `header_out` = 2'b11, payload still scrambled.
- Reset and seed collision:
  - Stimulus: assert `rst` between two valid words. Separately, apply `seed_load` and valid in the same cycle.
  - Required: outputs clear asynchronously, and the next word uses `SEED`. In the collision case, the word is scrambled with `seed`.
